// File: rtl/dff_mem_arbiter_if.sv
// Requester and RAM-side bus bundle for dff_mem_arbiter.
// Two requester ports (a_*, b_*) plus the single RAM access port (mem_*).
interface dff_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
);
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_gnt;
    logic              a_rvalid;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_gnt;
    logic              b_rvalid;
    logic [DATA_W-1:0] b_rdata;

    logic              mem_ce_n;
    logic              mem_lr_n;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side.
    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_gnt, a_rvalid, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_gnt, b_rvalid, b_rdata,
        output mem_ce_n, mem_lr_n, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Requester / RAM side.
    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_gnt, a_rvalid, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_gnt, b_rvalid, b_rdata,
        input  mem_ce_n, mem_lr_n, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dff_mem_arbiter.sv
// Two-port arbiter/sequencer for the 16-byte DFF register-file RAM; all outputs registered.
// Define DFF_MEM_RR_EN for round-robin arbitration; otherwise fixed priority A over B.
module dff_mem_arbiter #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    dff_mem_arbiter_if.slave      bus,
    output logic                  busy
);
    typedef enum logic [1:0] {StIdle, StIssue, StRdWait, StDone} state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;  // 1 = B owns the current access
    logic              a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
    logic              a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic              ce_n_q, ce_n_d, lr_n_q, lr_n_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              busy_q, busy_d;
    logic              pick_b;
    logic              win_we;

`ifdef DFF_MEM_RR_EN
    logic prio_b_q, prio_b_d;  // 1 = B wins a tie

    assign pick_b = bus.b_req & (~bus.a_req | prio_b_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) prio_b_q <= 1'b0;
        else     prio_b_q <= prio_b_d;
    end

    always_comb begin
        prio_b_d = prio_b_q;
        if (state_q == StIdle && (bus.a_req || bus.b_req)) prio_b_d = ~pick_b;
    end
`else
    assign pick_b = bus.b_req & ~bus.a_req;
`endif

    assign win_we = pick_b ? bus.b_we : bus.a_we;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        a_gnt_d    = 1'b0;
        b_gnt_d    = 1'b0;
        a_rvalid_d = 1'b0;
        b_rvalid_d = 1'b0;
        a_rdata_d  = a_rdata_q;
        b_rdata_d  = b_rdata_q;
        ce_n_d     = 1'b1;
        lr_n_d     = 1'b1;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        unique case (state_q)
            StIdle: begin
                if (bus.a_req || bus.b_req) begin
                    owner_d = pick_b;
                    addr_d  = pick_b ? bus.b_addr : bus.a_addr;
                    wdata_d = pick_b ? bus.b_wdata : bus.a_wdata;
                    lr_n_d  = ~win_we;
                    ce_n_d  = win_we;
                    a_gnt_d = ~pick_b;
                    b_gnt_d = pick_b;
                    state_d = StIssue;
                end
            end
            // lr_n_q low here marks the current access as a write.
            StIssue:  state_d = lr_n_q ? StRdWait : StIdle;
            StRdWait: begin
                if (owner_q) begin
                    b_rdata_d  = bus.mem_rdata;
                    b_rvalid_d = 1'b1;
                end else begin
                    a_rdata_d  = bus.mem_rdata;
                    a_rvalid_d = 1'b1;
                end
                state_d = StDone;
            end
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            owner_q    <= 1'b0;
            a_gnt_q    <= 1'b0;
            b_gnt_q    <= 1'b0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
            ce_n_q     <= 1'b1;
            lr_n_q     <= 1'b1;
            addr_q     <= '0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            a_gnt_q    <= a_gnt_d;
            b_gnt_q    <= b_gnt_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
            ce_n_q     <= ce_n_d;
            lr_n_q     <= lr_n_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.a_gnt     = a_gnt_q;
    assign bus.b_gnt     = b_gnt_q;
    assign bus.a_rvalid  = a_rvalid_q;
    assign bus.b_rvalid  = b_rvalid_q;
    assign bus.a_rdata   = a_rdata_q;
    assign bus.b_rdata   = b_rdata_q;
    assign bus.mem_ce_n  = ce_n_q;
    assign bus.mem_lr_n  = lr_n_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_dff_mem_arbiter.sv
// Directed bench for dff_mem_arbiter with a behavioural registered-read RAM.
// Expectations follow DFF_MEM_RR_EN when it is defined.
module tb_dff_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    int   n_checks = 0;
    int   n_fail = 0;

    dff_mem_arbiter_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    dff_mem_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    // RAM model: write when lr_n low, registered read when ce_n low.
    logic [7:0] ram [16];
    logic [7:0] ram_rdata = 8'h00;
    initial for (int i = 0; i < 16; i++) ram[i] = 8'h00;
    always @(posedge clk) begin
        if (!bus.mem_lr_n) ram[bus.mem_addr] <= bus.mem_wdata;
        if (!bus.mem_ce_n) ram_rdata <= ram[bus.mem_addr];
    end
    assign bus.mem_rdata = ram_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Single access from an idle DUT; called and returns at a negedge.
    task automatic access(input bit pb, input bit we, input logic [3:0] addr,
                          input logic [7:0] wd, input logic [7:0] exp_rd);
        if (pb) begin
            bus.b_req = 1'b1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wd;
        end else begin
            bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wd;
        end
        @(negedge clk);
        check("gnt_own", pb ? bus.b_gnt : bus.a_gnt, 1);
        check("gnt_other", pb ? bus.a_gnt : bus.b_gnt, 0);
        check("issue_lr_n", bus.mem_lr_n, we ? 0 : 1);
        check("issue_ce_n", bus.mem_ce_n, we ? 1 : 0);
        check("issue_addr", bus.mem_addr, addr);
        if (we) check("issue_wdata", bus.mem_wdata, wd);
        check("issue_busy", busy, 1);
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
        @(negedge clk);
        check("post_gnt", bus.a_gnt | bus.b_gnt, 0);
        check("post_lr_n", bus.mem_lr_n, 1);
        check("post_ce_n", bus.mem_ce_n, 1);
        if (!we) begin
            check("rdwait_rvalid", bus.a_rvalid | bus.b_rvalid, 0);
            @(negedge clk);
            check("rvalid_own", pb ? bus.b_rvalid : bus.a_rvalid, 1);
            check("rvalid_other", pb ? bus.a_rvalid : bus.b_rvalid, 0);
            check("rdata", pb ? bus.b_rdata : bus.a_rdata, exp_rd);
            @(negedge clk);
            check("rvalid_drop", bus.a_rvalid | bus.b_rvalid, 0);
        end
        check("end_busy", busy, 0);
    endtask

    task automatic check_reset_state();
        check("rst_ce_n", bus.mem_ce_n, 1);
        check("rst_lr_n", bus.mem_lr_n, 1);
        check("rst_busy", busy, 0);
        check("rst_gnt", {bus.a_gnt, bus.b_gnt, bus.a_rvalid, bus.b_rvalid}, 0);
        check("rst_a_rdata", bus.a_rdata, 0);
        check("rst_b_rdata", bus.b_rdata, 0);
        check("rst_addr", bus.mem_addr, 0);
        check("rst_wdata", bus.mem_wdata, 0);
    endtask

    initial begin
        bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
        bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;

        // 1: reset state
        @(negedge clk);
        @(negedge clk);
        check_reset_state();
        rst = 1'b0;
        @(negedge clk);

        // 2: A write 3 <- 5A, then A read 3
        access(1'b0, 1'b1, 4'd3, 8'h5A, 8'h00);
        access(1'b0, 1'b0, 4'd3, 8'h00, 8'h5A);

        // 3: B write 15 <- C3, A read 15
        access(1'b1, 1'b1, 4'd15, 8'hC3, 8'h00);
        access(1'b0, 1'b0, 4'd15, 8'h00, 8'hC3);

        // 4: both read continuously, from a fresh reset so the pointer favours A
        rst = 1'b1;
        @(negedge clk);
        check_reset_state();
        rst = 1'b0;
        bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 4'd3;
        bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 4'd15;
        for (int i = 0; i < 4; i++) begin
            bit exp_b;
`ifdef DFF_MEM_RR_EN
            exp_b = (i % 2) == 1;
`else
            exp_b = 1'b0;
`endif
            @(negedge clk);
            check("cont_a_gnt", bus.a_gnt, !exp_b);
            check("cont_b_gnt", bus.b_gnt, exp_b);
            @(negedge clk);
            @(negedge clk);
            check("cont_rvalid", {bus.a_rvalid, bus.b_rvalid}, exp_b ? 2'b01 : 2'b10);
            check("cont_rdata", exp_b ? bus.b_rdata : bus.a_rdata, exp_b ? 8'hC3 : 8'h5A);
            @(negedge clk);
        end
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("cont_idle_busy", busy, 0);

        // 5: reset during RDWAIT drops the read
        bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 4'd3;
        @(negedge clk);
        check("rd5_gnt", bus.a_gnt, 1);
        bus.a_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_a_rdata", bus.a_rdata, 0);
        check("midrst_ce_n", bus.mem_ce_n, 1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("midrst_no_rvalid", bus.a_rvalid, 0);
            check("midrst_rdata_held", bus.a_rdata, 0);
        end
        access(1'b0, 1'b1, 4'd7, 8'h11, 8'h00);
        access(1'b0, 1'b0, 4'd7, 8'h00, 8'h11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
